// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter and drives
// the instruction memory address, and registers the fetched instruction
// into the IF/ID register. A taken jump redirects the PC and replaces
// the IF/ID contents with one NOP bubble. Stall freezes the stage, and
// halt stops fetching until reset.
//
// Handshake: this stage has no valid/ready pair. Downstream applies
// back-pressure with 'stall', which freezes PC and IF/ID on the same edge.
// 'valid' marks IF/ID as holding a real fetched instruction; bubbles
// (boot, jump flush, halt) present NOP_INSTR with valid=0.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   stall               freeze PC and IF/ID (RUN only)
//   halt_req            enter terminal HALTED state
//   jump, jump_address  taken jump and target, from the jump decoder
//   imem_addr           instruction memory address (= pc)
//   imem_data           asynchronous read data for imem_addr
//   instruction         IF/ID instruction
//   instr_pc            PC of the IF/ID instruction
//   valid               IF/ID holds a real instruction
//   halted              high while in HALTED
module fetch_unit #(
  parameter int                   PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [15:0]          NOP_INSTR = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_address,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic [15:0]         instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                valid,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    case (state_q)
      // One settling cycle after reset: nothing is loaded, stall ignored.
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          // Hold everything. A jump decoded from the held instruction is
          // still asserted once the stall releases, so it is not lost.
        end else if (jump) begin
          // Redirect; the word fetched this cycle is on the wrong path.
          pc_d    = jump_address;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (halt_req) begin
          state_d  = ST_HALTED;
          instr_d  = NOP_INSTR;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_ONE;  // wraps silently
        end
      end
      ST_HALTED: begin
        // Terminal: only reset leaves this state.
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign valid       = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A behavioural instruction
// memory and a jump decoder (opcode 4'hF => jump to zero-extended [11:0])
// surround the DUT. A second instance with RESET_PC=16'hFFFF covers the
// PC wrap on the first fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, halt_req;
  logic        force_jump;
  logic [15:0] force_addr;
  logic        jump;
  logic [15:0] jump_address;
  logic [15:0] imem_addr, imem_data, instruction, instr_pc;
  logic        valid, halted;

  logic [15:0] imem_addr2, imem_data2, instruction2, instr_pc2;
  logic        valid2, halted2;

  logic [15:0] mem [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data  = mem[imem_addr];
  assign imem_data2 = mem[imem_addr2];

  // Jump decoder model, plus a bench override to inject jumps directly.
  logic        dec_jump;
  assign dec_jump     = (instruction[15:12] == 4'hF);
  assign jump         = dec_jump | force_jump;
  assign jump_address = force_jump ? force_addr : {4'h0, instruction[11:0]};

  fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .halt_req     (halt_req),
    .jump         (jump),
    .jump_address (jump_address),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .valid        (valid),
    .halted       (halted)
  );

  fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'hFFFF), .NOP_INSTR(16'h0000)) dut_wrap (
    .clk          (clk),
    .reset        (reset),
    .stall        (1'b0),
    .halt_req     (1'b0),
    .jump         (1'b0),
    .jump_address (16'h0000),
    .imem_addr    (imem_addr2),
    .imem_data    (imem_data2),
    .instruction  (instruction2),
    .instr_pc     (instr_pc2),
    .valid        (valid2),
    .halted       (halted2)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] e_pc, input logic [15:0] e_ins,
                           input logic [15:0] e_ipc, input logic e_valid, input logic e_halted);
    check_eq({tag, ".pc"},     imem_addr,          e_pc);
    check_eq({tag, ".instr"},  instruction,        e_ins);
    check_eq({tag, ".ipc"},    instr_pc,           e_ipc);
    check_eq({tag, ".valid"},  {15'h0, valid},     {15'h0, e_valid});
    check_eq({tag, ".halted"}, {15'h0, halted},    {15'h0, e_halted});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1000;
    mem[16'h0001] = 16'h1001;
    mem[16'h0002] = 16'h1002;
    mem[16'h0003] = 16'hF02A;
    mem[16'h002A] = 16'h2A2A;
    mem[16'h002B] = 16'hF005;
    mem[16'h0005] = 16'h5555;
    mem[16'h0040] = 16'h4040;
    mem[16'hFFFF] = 16'hABCD;

    reset = 1'b1; stall = 1'b0; halt_req = 1'b0;
    force_jump = 1'b0; force_addr = 16'h0000;
    tick();
    check_out("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check_eq("wrap.rst_pc", imem_addr2, 16'hFFFF);
    reset = 1'b0;

    // BOOT cycle, stall ignored
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check_out("boot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    check_eq("wrap.boot_valid", {15'h0, valid2}, 16'h0000);

    tick();
    check_out("f0", 16'h0001, 16'h1000, 16'h0000, 1'b1, 1'b0);
    check_eq("wrap.ipc",   instr_pc2,      16'hFFFF);
    check_eq("wrap.instr", instruction2,   16'hABCD);
    check_eq("wrap.pc",    imem_addr2,     16'h0000);
    check_eq("wrap.valid", {15'h0, valid2}, 16'h0001);
    tick();
    check_out("f1", 16'h0002, 16'h1001, 16'h0001, 1'b1, 1'b0);
    tick();
    check_out("f2", 16'h0003, 16'h1002, 16'h0002, 1'b1, 1'b0);
    tick();
    check_out("f3", 16'h0004, 16'hF02A, 16'h0003, 1'b1, 1'b0);

    // jump decoded from F02A -> bubble, pc=2A
    tick();
    check_out("jmp_bub", 16'h002A, 16'h0000, 16'h0003, 1'b0, 1'b0);
    tick();
    check_out("jmp_tgt", 16'h002B, 16'h2A2A, 16'h002A, 1'b1, 1'b0);
    tick();
    check_out("f2b", 16'h002C, 16'hF005, 16'h002B, 1'b1, 1'b0);

    // stall 3 cycles with the jump pending
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("stall%0d", i), 16'h002C, 16'hF005, 16'h002B, 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick();
    check_out("stall_rel", 16'h0005, 16'h0000, 16'h002B, 1'b0, 1'b0);
    tick();
    check_out("f5", 16'h0006, 16'h5555, 16'h0005, 1'b1, 1'b0);

    // jump and halt together: jump wins, halt follows
    force_jump = 1'b1; force_addr = 16'h0040; halt_req = 1'b1;
    tick();
    force_jump = 1'b0;
    check_out("jh_jump", 16'h0040, 16'h0000, 16'h0005, 1'b0, 1'b0);
    tick();
    check_out("jh_halt", 16'h0040, 16'h0000, 16'h0005, 1'b0, 1'b1);

    // HALTED ignores everything but reset
    for (int i = 0; i < 4; i++) begin
      stall = i[0]; force_jump = i[1]; force_addr = 16'h0077; halt_req = ~i[0];
      tick();
      check_out($sformatf("halted%0d", i), 16'h0040, 16'h0000, 16'h0005, 1'b0, 1'b1);
    end
    stall = 1'b0; force_jump = 1'b0; halt_req = 1'b0;

    // reset while HALTED
    reset = 1'b1;
    tick();
    check_out("rst_halt", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("rst_halt_boot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    check_out("rst_halt_f0", 16'h0001, 16'h1000, 16'h0000, 1'b1, 1'b0);
    tick();
    check_out("rst_halt_f1", 16'h0002, 16'h1001, 16'h0001, 1'b1, 1'b0);

    // reset while stalled
    stall = 1'b1; reset = 1'b1;
    tick();
    check_out("rst_stall", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("rst_stall_boot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    stall = 1'b0;

    // reset with a jump pending in IF/ID
    for (int i = 0; i < 4; i++) tick();
    check_out("pre_rst_jmp", 16'h0004, 16'hF02A, 16'h0003, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check_out("rst_jmp", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("rst_jmp_boot", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    check_out("rst_jmp_f0", 16'h0001, 16'h1000, 16'h0000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that owns the program counter and drives the instruction memory address.
- Registers the fetched 16-bit instruction into the IF/ID register.
- Consumes jump/address from the downstream jump decoder. A taken jump redirects the PC and flushes the IF/ID register with one bubble.
- Supports downstream stall and a terminal halt state.

Parameters:
- PC_WIDTH, 16, width of PC, imem address and jump_address.
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, instruction value inserted on flush, boot and halt.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold request from downstream; freezes PC and IF/ID register
- halt_req  input  1  request to stop fetching permanently (until reset)
- jump  input  1  taken-jump flag from jump decoder, derived combinationally from instruction
- jump_address  input  PC_WIDTH  jump target from decoder, already zero-extended
- imem_addr  output  PC_WIDTH  instruction memory read address, equal to pc_reg (combinational)
- imem_data  input  16  instruction memory read data, combinational/asynchronous read of imem_addr
- instruction  output  16  IF/ID registered instruction, fed to jump decoder and decode
- instr_pc  output  PC_WIDTH  PC of the instruction currently in IF/ID
- valid  output  1  IF/ID holds a real fetched instruction
- halted  output  1  high while in HALTED state

Behaviour:
- Clock/reset: single clock clk. Reset is synchronous, active-high, via the reset port.
- Reset values: pc_reg=RESET_PC, instruction=NOP_INSTR, instr_pc=0, valid=0, halted=0, state=BOOT.
- Reset asserted mid-operation (any state, including during stall or jump) wins over all other inputs on that edge.
- State BOOT (one cycle after reset):
  - No IF/ID load; valid stays 0.
  - Next state RUN unconditionally; stall is ignored.
- State RUN, priority order evaluated each edge:
  1. stall=1: pc_reg, instruction, instr_pc, valid all hold. jump and halt_req are ignored this cycle. A jump stays pending because it is decoded from the held instruction.
  2. jump=1:
     - pc_reg<=jump_address.
     - instruction<=NOP_INSTR, valid<=0; instr_pc holds.
     - imem_data for the current cycle is discarded.
     - The bubble's NOP opcode is not a jump, so no re-trigger.
  3. halt_req=1:
     - state<=HALTED, instruction<=NOP_INSTR, valid<=0, halted<=1.
     - pc_reg holds, with no increment.
  4. Otherwise:
     - instruction<=imem_data, instr_pc<=pc_reg, valid<=1.
     - pc_reg<=pc_reg+1, modulo 2^PC_WIDTH; 16'hFFFF wraps to 16'h0000 silently.
- State HALTED:
  - All registers hold; valid=0, halted=1.
  - stall, jump and halt_req are ignored. Only reset exits.
- Jump and halt_req both high, no stall: jump wins. Halt is taken next cycle if halt_req is still high; the bubble is not lost.
- Latency:
  - Instruction at address A appears on instruction/valid one edge after pc_reg=A (unstalled).
  - Jump penalty is exactly one bubble cycle.
- Throughput: steady state one instruction per cycle.
- imem_addr always equals pc_reg, including in BOOT and HALTED.

Test Plan:
- Reset, then 5 unstalled cycles with imem[n]=16'h1000+n:
  - Cycle after BOOT: valid=0.
  - Then instruction=1000,1001,1002, instr_pc=0,1,2, valid=1 each cycle.
- Jump at address 3, imem[3]=16'hF02A:
  - Next edge: instruction=0000, valid=0, pc_reg=16'h002A.
  - Following edge: instruction=imem[0x2A], instr_pc=0x2A, valid=1.
- Stall 3 cycles while a jump (16'hF005) is in IF/ID:
  - pc_reg, instruction, valid frozen for all 3 cycles.
  - On stall release, pc_reg=5 and a bubble is inserted.
- Preload pc_reg=16'hFFFF via RESET_PC=16'hFFFF: after reset and BOOT, the first fetch gives instr_pc=FFFF, then pc_reg=0000.
- halt_req in the same cycle as jump:
  - Jump taken (pc_reg=target, bubble).
  - Next cycle with halt_req still high: halted=1, valid=0, pc_reg holds; stall/jump toggling has no effect.
- Reset asserted while stalled, mid-jump, and while HALTED: every output returns to its reset value in one edge; BOOT follows.
